// File: rtl/data_mem_unit.sv
// data_mem_unit: word-addressed data memory placed downstream of the multicycle
// control unit / datapath. The MEM state drives the requests. Load data is
// registered, so it stays stable for the whole of the following WB state.
// Sticky error flags and saturating access counters are provided for debug.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous reset, active-high (RAM contents are kept)
//   MemRead        read request (level)
//   MemWrite       write request (level, wins over MemRead)
//   dAddress       byte address
//   dWriteData     store data
//   dReadData      registered load data (0 for an invalid read)
//   err_misaligned sticky: an access started with dAddress[1:0] != 0
//   err_range      sticky: an access started outside the data segment
//   rd_count       read accesses started, saturating
//   wr_count       write accesses started, saturating
module data_mem_unit #(
    parameter logic [31:0] DATA_BASE   = 32'h10010000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        err_misaligned,
    output logic        err_range,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       off;
    logic              inRange;
    logic              aligned;
    logic              valid;
    logic [ADDR_W-1:0] idx;
    logic              rd;
    logic              wr;
    logic              prevRd;
    logic              prevWr;
    logic              rdStart;
    logic              wrStart;

    // The explicit lower-bound test keeps addresses below DATA_BASE from
    // wrapping the subtraction around into the RAM window.
    always_comb begin
        off     = dAddress - DATA_BASE;
        inRange = (dAddress >= DATA_BASE) && (off < SPAN);
        aligned = (dAddress[1:0] == 2'b00);
        valid   = inRange && aligned;
        idx     = off[ADDR_W+1:2];
        wr      = MemWrite;
        rd      = MemRead && !MemWrite;
        // A request held high across MEM and WB counts as a single access.
        rdStart = rd && !prevRd;
        wrStart = wr && !prevWr;
    end

    // The RAM has no reset, but a write in the reset cycle is still ignored.
    always_ff @(posedge clk) begin
        if (!rst && wr && valid) begin
            mem[idx] <= dWriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dReadData      <= '0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
            prevRd         <= 1'b0;
            prevWr         <= 1'b0;
        end else begin
            prevRd <= rd;
            prevWr <= wr;
            if (rd) begin
                dReadData <= valid ? mem[idx] : '0;
            end
            if (rdStart && rd_count != '1) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wrStart && wr_count != '1) begin
                wr_count <= wr_count + 16'd1;
            end
            if ((rdStart || wrStart) && !aligned) begin
                err_misaligned <= 1'b1;
            end
            if ((rdStart || wrStart) && !inRange) begin
                err_range <= 1'b1;
            end
        end
    end

endmodule
